// File: rtl/pipeline_mem_bridge_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_mem_bridge_pkg
// Shared types and constants for the pipeline fetch/access bus bridge:
//   - state_t       : bridge FSM states (3-bit encoding)
//   - NOP_INST      : instruction returned when a fetch is suppressed
//   - DEF_ADDR_W/DEF_DATA_W : default address/data widths
//   - MASK_W        : byte-strobe width
//   - pick_word()   : selects the 32-bit instruction half of a 64-bit beat
// -----------------------------------------------------------------------------
package pipeline_mem_bridge_pkg;

   localparam int DEF_ADDR_W = 64;
   localparam int DEF_DATA_W = 64;
   localparam int MASK_W     = 8;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_D_REQ  = 3'd1,
      S_D_RESP = 3'd2,
      S_F_REQ  = 3'd3,
      S_F_RESP = 3'd4
   } state_t;

   // Instructions are 32 bits wide; address bit 2 picks the half of the beat.
   function automatic logic [31:0] pick_word(input logic upper, input logic [63:0] beat);
      return upper ? beat[63:32] : beat[31:0];
   endfunction

endpackage

// File: rtl/pipeline_mem_bridge_if.sv
// -----------------------------------------------------------------------------
// pipeline_mem_bridge_if
// Single-outstanding request/response memory bus.
//   valid/ready          : request handshake (master -> slave)
//   addr/wen/wdata/wmask : request payload, held stable while valid
//   resp_valid/rdata     : one response beat per request (slave -> master)
// Modports: master (the bridge), slave (memory / bus port).
// -----------------------------------------------------------------------------
interface pipeline_mem_bridge_if
   import pipeline_mem_bridge_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              valid;
   logic              ready;
   logic [ADDR_W-1:0] addr;
   logic              wen;
   logic [DATA_W-1:0] wdata;
   logic [MASK_W-1:0] wmask;
   logic              resp_valid;
   logic [DATA_W-1:0] rdata;

   modport master (
      output valid, addr, wen, wdata, wmask,
      input  ready, resp_valid, rdata
   );

   modport slave (
      input  valid, addr, wen, wdata, wmask,
      output ready, resp_valid, rdata
   );

endinterface

// File: rtl/pipeline_mem_bridge_wdog.sv
// -----------------------------------------------------------------------------
// pipeline_mem_bridge_wdog
// Response watchdog. Counts cycles spent waiting for a response beat and
// flags expiry on the TIMEOUT_CYCLES-th waiting cycle.
//   clk, rst : clock, asynchronous active-low reset
//   run      : high while the bridge waits for a response; low clears the count
//   expired  : waiting limit reached this cycle
// Only instantiated when PIPELINE_MEM_BRIDGE_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module pipeline_mem_bridge_wdog #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic expired
);

   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [CNT_W-1:0] count;

   // The count sits at zero outside the response states, so every entry
   // starts a fresh window.
   assign expired = run && (count == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          count <= '0;
      else if (!run)     count <= '0;
      else if (!expired) count <= count + 1'b1;
   end

endmodule

// File: rtl/pipeline_mem_bridge.sv
// -----------------------------------------------------------------------------
// pipeline_mem_bridge
// Responder side of the pipeline fetch/access handshake. Serves the IF-stage
// instruction fetch and the MEM-stage data access over one shared
// single-outstanding bus; data accesses always win over fetches.
//   clk, rst              : clock, asynchronous active-low reset
//   advance               : pipeline advance pulse; clears both ok flags
//   if_pc, if_dont_fetch  : fetch address; suppress bus fetch and return a NOP
//   fetched_ok, if_inst   : sticky instruction-ready flag and instruction
//   mem_read/mem_write    : data access request
//   mem_addr/wdata/wmask  : data access payload
//   access_ok, mem_rdata  : sticky access-done flag and raw read beat
//   bus                   : memory bus (master modport)
//   bus_err               : sticky response-timeout error
// Optional: PIPELINE_MEM_BRIDGE_TIMEOUT_EN enables the response watchdog.
// -----------------------------------------------------------------------------
module pipeline_mem_bridge
   import pipeline_mem_bridge_pkg::*;
#(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 advance,
   input  logic [ADDR_W-1:0]    if_pc,
   input  logic                 if_dont_fetch,
   output logic                 fetched_ok,
   output logic [31:0]          if_inst,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic [ADDR_W-1:0]    mem_addr,
   input  logic [DATA_W-1:0]    mem_wdata,
   input  logic [MASK_W-1:0]    mem_wmask,
   output logic                 access_ok,
   output logic [DATA_W-1:0]    mem_rdata,
   pipeline_mem_bridge_if.master bus,
   output logic                 bus_err
);

   state_t state, next_state;

   logic data_req;     // MEM stage has an access that is not yet done
   logic start_d;      // IDLE launches a data request
   logic start_f;      // IDLE launches a fetch request
   logic nop_fill;     // IDLE completes a suppressed fetch with a NOP
   logic resp_wait;    // waiting for a response beat
   logic timeout;      // watchdog gave up on the response
   logic resp_done;    // response phase ends this cycle
   logic fetch_set;
   logic access_set;

   assign data_req   = (mem_read | mem_write) & ~access_ok;
   assign start_d    = (state == S_IDLE) && data_req;
   assign start_f    = (state == S_IDLE) && !data_req && !fetched_ok && !if_dont_fetch;
   assign nop_fill   = (state == S_IDLE) && !data_req && !fetched_ok &&  if_dont_fetch;
   assign resp_wait  = (state == S_D_RESP) || (state == S_F_RESP);
   assign resp_done  = bus.resp_valid | timeout;
   assign fetch_set  = nop_fill || ((state == S_F_RESP) && resp_done);
   assign access_set = (state == S_D_RESP) && resp_done;

   // Valid is a pure decode of a registered state, so it is glitch-free and
   // falls on the same edge that accepts the request.
   assign bus.valid = (state == S_D_REQ) || (state == S_F_REQ);

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: non-blocking assignments for every register so all state
      // updates see pre-edge values regardless of process ordering.
      if (!rst) state <= S_IDLE;
      else      state <= next_state;
   end

   always_comb begin
      // NOTE: default assigned first so every path drives next_state; no latch.
      next_state = state;
      unique case (state)
         S_IDLE: begin
            if (start_d)      next_state = S_D_REQ;
            else if (start_f) next_state = S_F_REQ;
         end
         S_D_REQ:  if (bus.ready) next_state = S_D_RESP;
         S_D_RESP: if (resp_done) next_state = S_IDLE;
         S_F_REQ:  if (bus.ready) next_state = S_F_RESP;
         S_F_RESP: if (resp_done) next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // Sticky completion flags; advance wins over a same-cycle set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetched_ok <= 1'b0;
         access_ok  <= 1'b0;
      end else if (advance) begin
         fetched_ok <= 1'b0;
         access_ok  <= 1'b0;
      end else begin
         if (fetch_set)  fetched_ok <= 1'b1;
         if (access_set) access_ok  <= 1'b1;
      end
   end

   // Request payload is captured on leaving IDLE and held until the next
   // request; result registers only change when a result arrives.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.addr  <= '0;
         bus.wen   <= 1'b0;
         bus.wdata <= '0;
         bus.wmask <= '0;
         if_inst   <= '0;
         mem_rdata <= '0;
      end else begin
         if (start_d) begin
            bus.addr  <= mem_addr;
            bus.wen   <= mem_write;
            bus.wdata <= mem_wdata;
            bus.wmask <= mem_write ? mem_wmask : '0;
         end else if (start_f) begin
            bus.addr  <= if_pc;
            bus.wen   <= 1'b0;
            bus.wdata <= '0;
            bus.wmask <= '0;
         end

         if (nop_fill)
            if_inst <= NOP_INST;
         else if ((state == S_F_RESP) && resp_done)
            if_inst <= bus.resp_valid ? pick_word(if_pc[2], bus.rdata[63:0]) : '0;

         if (access_set)
            mem_rdata <= bus.resp_valid ? bus.rdata : '0;
      end
   end

`ifdef PIPELINE_MEM_BRIDGE_TIMEOUT_EN
   pipeline_mem_bridge_wdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .run     (resp_wait),
      .expired (timeout)
   );

   // A real response beat in the expiry cycle still counts as a success.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                             bus_err <= 1'b0;
      else if (timeout && !bus.resp_valid)  bus_err <= 1'b1;
   end
`else
   // Watchdog compiled out: responses are awaited indefinitely and the
   // limit parameter has no effect (the comparison is constant-false).
   assign timeout = (TIMEOUT_CYCLES < 0) && resp_wait;
   assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_mem_bridge.sv
// -----------------------------------------------------------------------------
// tb_pipeline_mem_bridge
// Directed bench for pipeline_mem_bridge. The bench plays the bus slave;
// expected instructions / read data are queued when a response beat is
// planned and popped when the matching ok flag rises.
// -----------------------------------------------------------------------------
module tb_pipeline_mem_bridge;
   import pipeline_mem_bridge_pkg::*;

   localparam int AW = 64;
   localparam int DW = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic            advance;
   logic [AW-1:0]   if_pc;
   logic            if_dont_fetch;
   logic            fetched_ok;
   logic [31:0]     if_inst;
   logic            mem_read;
   logic            mem_write;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [MASK_W-1:0] mem_wmask;
   logic            access_ok;
   logic [DW-1:0]   mem_rdata;
   logic            bus_err;

   pipeline_mem_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   pipeline_mem_bridge #(
      .ADDR_W         (AW),
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .advance       (advance),
      .if_pc         (if_pc),
      .if_dont_fetch (if_dont_fetch),
      .fetched_ok    (fetched_ok),
      .if_inst       (if_inst),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_wmask     (mem_wmask),
      .access_ok     (access_ok),
      .mem_rdata     (mem_rdata),
      .bus           (bus),
      .bus_err       (bus_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit          is_data;
      logic [63:0] value;
   } exp_t;

   exp_t sb_q[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input bit is_data, input logic [63:0] value);
      exp_t e;
      e.is_data = is_data;
      e.value   = value;
      sb_q.push_back(e);
   endtask

   task automatic sb_check(input string tag, input bit is_data, input logic [63:0] obs);
      exp_t e;
      total++;
      assert (sb_q.size() != 0) else begin
         bad++;
         $error("FAIL %s observed=%h expected=<queued result>", tag, obs);
      end
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check1({tag, "_kind"}, is_data, e.is_data);
         check({tag, "_value"}, obs, e.value);
      end
   endtask

   // Waits (bounded) for a request, checks its payload, stalls ready for
   // 'stall' cycles while checking stability, then accepts it.
   task automatic accept_req(input string tag, input logic [63:0] addr, input logic wen,
                             input logic [7:0] wmask, input logic [63:0] wdata, input int stall);
      int n = 0;
      while (!bus.valid && n < 20) begin
         step();
         n++;
      end
      check1({tag, "_valid"}, bus.valid, 1'b1);
      check({tag, "_addr"}, bus.addr, addr);
      check1({tag, "_wen"}, bus.wen, wen);
      check({tag, "_wmask"}, 64'(bus.wmask), 64'(wmask));
      if (wen) check({tag, "_wdata"}, bus.wdata, wdata);
      for (int i = 0; i < stall; i++) begin
         step();
         check1({tag, "_stall_valid"}, bus.valid, 1'b1);
         check({tag, "_stall_addr"}, bus.addr, addr);
      end
      bus.ready = 1'b1;
      step();
      bus.ready = 1'b0;
      check1({tag, "_valid_drop"}, bus.valid, 1'b0);
   endtask

   task automatic respond(input logic [63:0] beat);
      bus.resp_valid = 1'b1;
      bus.rdata      = beat;
      step();
      bus.resp_valid = 1'b0;
      bus.rdata      = '0;
   endtask

   // Illegal-condition monitors: advance during a bus request, and request
   // inputs changing while a request is presented.
   logic [201:0] req_snap;
   logic         prev_valid = 1'b0;
   always @(negedge clk) begin
      if (rst && bus.valid && advance) begin
         bad++;
         $error("FAIL illegal_advance observed=1 expected=0");
      end
      if (rst && bus.valid && prev_valid &&
          req_snap != {if_pc, mem_read, mem_write, mem_addr, mem_wdata, mem_wmask}) begin
         bad++;
         $error("FAIL req_inputs_stable observed=changed expected=stable");
      end
      req_snap   = {if_pc, mem_read, mem_write, mem_addr, mem_wdata, mem_wmask};
      prev_valid = bus.valid;
   end

   initial begin
      rst            = 1'b1;
      advance        = 1'b0;
      if_pc          = '0;
      if_dont_fetch  = 1'b0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_addr       = '0;
      mem_wdata      = '0;
      mem_wmask      = '0;
      bus.ready      = 1'b0;
      bus.resp_valid = 1'b0;
      bus.rdata      = '0;

      // ---------------- reset state ----------------
      #2 rst = 1'b0;
      step();
      step();
      check1("rst_fetched_ok", fetched_ok, 1'b0);
      check1("rst_access_ok", access_ok, 1'b0);
      check1("rst_valid", bus.valid, 1'b0);
      check1("rst_wen", bus.wen, 1'b0);
      check1("rst_err", bus_err, 1'b0);
      check("rst_inst", 64'(if_inst), 64'h0);
      check("rst_addr", bus.addr, 64'h0);

      // ---------------- fetch only, exact latency ----------------
      if_pc = 64'h8000_0004;
      rst   = 1'b1;
      step();                                         // cycle 1
      check1("f1_valid", bus.valid, 1'b1);
      check("f1_addr", bus.addr, 64'h8000_0004);
      check1("f1_wen", bus.wen, 1'b0);
      check("f1_wmask", 64'(bus.wmask), 64'h0);
      bus.ready = 1'b1;
      step();                                         // cycle 2
      bus.ready = 1'b0;
      check1("f1_valid_drop", bus.valid, 1'b0);
      check1("f1_not_yet", fetched_ok, 1'b0);
      sb_push(1'b0, 64'hDEAD_BEEF);
      respond(64'hDEAD_BEEF_0010_0093);               // cycle 3
      check1("f1_fetched_ok", fetched_ok, 1'b1);
      sb_check("f1_inst", 1'b0, 64'(if_inst));
      step();                                         // cycle 4
      check1("f1_sticky", fetched_ok, 1'b1);
      step();                                         // cycle 5

      // ---------------- load + pending fetch: data first ----------------
      advance   = 1'b1;
      mem_read  = 1'b1;
      mem_addr  = 64'h8000_1000;
      if_pc     = 64'h8000_0008;
      sb_push(1'b1, 64'hCAFE_BABE_1234_5678);
      sb_push(1'b0, 64'h2222_2222);
      step();                                         // cycle 6
      advance = 1'b0;
      check1("f1_adv_clear", fetched_ok, 1'b0);
      accept_req("ld", 64'h8000_1000, 1'b0, 8'h00, 64'h0, 0);
      respond(64'hCAFE_BABE_1234_5678);
      check1("ld_access_ok", access_ok, 1'b1);
      check1("ld_fetch_after", fetched_ok, 1'b0);
      sb_check("ld_rdata", 1'b1, mem_rdata);
      accept_req("ld_f", 64'h8000_0008, 1'b0, 8'h00, 64'h0, 0);
      respond(64'h1111_1111_2222_2222);
      check1("ld_f_fetched_ok", fetched_ok, 1'b1);
      check1("ld_f_access_hold", access_ok, 1'b1);
      sb_check("ld_f_inst", 1'b0, 64'(if_inst));

      // ---------------- store, then suppressed fetch ----------------
      advance       = 1'b1;
      mem_read      = 1'b0;
      mem_write     = 1'b1;
      mem_addr      = 64'h8000_2000;
      mem_wdata     = 64'h1122_3344_5566_7788;
      mem_wmask     = 8'h0F;
      if_dont_fetch = 1'b1;
      sb_push(1'b0, 64'(NOP_INST));
      step();
      advance = 1'b0;
      check1("st_adv_access", access_ok, 1'b0);
      check1("st_adv_fetch", fetched_ok, 1'b0);
      accept_req("st", 64'h8000_2000, 1'b1, 8'h0F, 64'h1122_3344_5566_7788, 0);
      check1("st_wait_beat", access_ok, 1'b0);
      respond(64'h0);
      check1("st_access_ok", access_ok, 1'b1);
      check1("nop_not_yet", fetched_ok, 1'b0);
      step();
      check1("nop_fetched_ok", fetched_ok, 1'b1);
      check1("nop_no_bus", bus.valid, 1'b0);
      sb_check("nop_inst", 1'b0, 64'(if_inst));

      // ---------------- advance beats a same-cycle flag set ----------------
      advance   = 1'b1;
      mem_write = 1'b0;
      step();
      check1("prio_clear", fetched_ok, 1'b0);
      step();
      check1("prio_adv_wins", fetched_ok, 1'b0);
      advance = 1'b0;
      sb_push(1'b0, 64'(NOP_INST));
      step();
      check1("prio_set_after", fetched_ok, 1'b1);
      sb_check("prio_inst", 1'b0, 64'(if_inst));

      // ---------------- backpressure, then reset in F_RESP ----------------
      advance       = 1'b1;
      if_dont_fetch = 1'b0;
      if_pc         = 64'h8000_0010;
      step();
      advance = 1'b0;
      accept_req("bp", 64'h8000_0010, 1'b0, 8'h00, 64'h0, 4);
      rst = 1'b0;
      #1;
      check1("ar_fetched_ok", fetched_ok, 1'b0);
      check1("ar_access_ok", access_ok, 1'b0);
      check1("ar_valid", bus.valid, 1'b0);
      check("ar_inst", 64'(if_inst), 64'h0);
      check("ar_addr", bus.addr, 64'h0);
      check("ar_rdata", mem_rdata, 64'h0);
      if_pc = 64'h8000_0014;
      step();
      rst = 1'b1;
      sb_push(1'b0, 64'hA5A5_A5A5);
      accept_req("ar_f", 64'h8000_0014, 1'b0, 8'h00, 64'h0, 0);
      respond(64'hA5A5_A5A5_5A5A_5A5A);
      check1("ar_f_fetched_ok", fetched_ok, 1'b1);
      sb_check("ar_f_inst", 1'b0, 64'(if_inst));

`ifdef PIPELINE_MEM_BRIDGE_TIMEOUT_EN
      // ---------------- response timeout ----------------
      advance = 1'b1;
      if_pc   = 64'h8000_0018;
      step();
      advance = 1'b0;
      sb_push(1'b0, 64'h0);
      accept_req("to", 64'h8000_0018, 1'b0, 8'h00, 64'h0, 0);
      for (int i = 0; i < 30 && !fetched_ok; i++) step();
      check1("to_fetched_ok", fetched_ok, 1'b1);
      check1("to_err", bus_err, 1'b1);
      sb_check("to_inst", 1'b0, 64'(if_inst));
`else
      check1("no_wdog_err", bus_err, 1'b0);
`endif

      check("sb_drained", 64'(sb_q.size()), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
